// File: rtl/vga_tile_render_pkg.sv
// Shared constants, FSM state type and palette for the tile renderer.
// Screen geometry: 80x30 cells of 8x16 pixels on a 640x480 display.
// Palette: 16 RGB444 foreground colours selected by the upper nibble
// of each tile map entry.
package vga_tile_render_pkg;

  localparam int TILE_COLS  = 80;
  localparam int TILE_ROWS  = 30;
  localparam int TILE_CELLS = 2400;
  localparam int CELL_W     = 8;
  localparam int CELL_H     = 16;

  localparam logic [11:0] PALETTE_0 = 12'h444;
  localparam logic [11:0] PALETTE_1 = 12'h00F;
  localparam logic [11:0] PALETTE_2 = 12'h0F0;
  localparam logic [11:0] PALETTE_3 = 12'h0FF;
  localparam logic [11:0] PALETTE_4 = 12'hF00;
  localparam logic [11:0] PALETTE_5 = 12'hF0F;
  localparam logic [11:0] PALETTE_6 = 12'hFF0;
  localparam logic [11:0] PALETTE_7 = 12'hFFF;
  localparam logic [11:0] PALETTE_8 = 12'h888;
  localparam logic [11:0] PALETTE_9 = 12'h08F;
  localparam logic [11:0] PALETTE_A = 12'h8F0;
  localparam logic [11:0] PALETTE_B = 12'h0F8;
  localparam logic [11:0] PALETTE_C = 12'hF80;
  localparam logic [11:0] PALETTE_D = 12'hF08;
  localparam logic [11:0] PALETTE_E = 12'h80F;
  localparam logic [11:0] PALETTE_F = 12'hCCC;

  // CLEAR wipes the tile map after reset; RUN serves pixels and host writes
  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  function automatic logic [11:0] paletteLookup(input logic [3:0] idx);
    logic [11:0] color;
    case (idx)
      4'h0:    color = PALETTE_0;
      4'h1:    color = PALETTE_1;
      4'h2:    color = PALETTE_2;
      4'h3:    color = PALETTE_3;
      4'h4:    color = PALETTE_4;
      4'h5:    color = PALETTE_5;
      4'h6:    color = PALETTE_6;
      4'h7:    color = PALETTE_7;
      4'h8:    color = PALETTE_8;
      4'h9:    color = PALETTE_9;
      4'hA:    color = PALETTE_A;
      4'hB:    color = PALETTE_B;
      4'hC:    color = PALETTE_C;
      4'hD:    color = PALETTE_D;
      4'hE:    color = PALETTE_E;
      default: color = PALETTE_F;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/vga_tile_render_glyph_rom.sv
// Combinational hex-digit font ROM.
// Ports:
//   glyph_i  glyph code 0..F (hex digit to draw)
//   row_i    pixel row inside the 16-row cell
//   bits_o   8-pixel row bitmap, bit 7 = leftmost pixel
// The font is a classic 5x7 design: rows 0-1 are blank, then each font
// row is doubled vertically to fill rows 2-15. The 5 font columns sit in
// bits 6..2 so there is one blank column left and two on the right.
module vga_glyph_rom
  import vga_tile_render_pkg::*;
(
  input  logic [3:0] glyph_i,
  input  logic [3:0] row_i,
  output logic [7:0] bits_o
);

  logic [34:0] font;
  logic [34:0] shifted;
  logic [3:0]  rowOff;
  logic [2:0]  fontRow;

  // Each glyph is packed top row first, 5 bits per row; shifting left by
  // 5*fontRow brings the wanted row into the top 5 bits.
  always_comb begin
    font = '0;
    case (glyph_i)
      4'h0: font = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      4'h1: font = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      4'h2: font = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      4'h3: font = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      4'h4: font = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      4'h5: font = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      4'h6: font = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      4'h7: font = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      4'h8: font = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'h9: font = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      4'hA: font = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
      4'hB: font = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      4'hC: font = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      4'hD: font = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      4'hE: font = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      default: font = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
    endcase
    rowOff  = row_i - 4'd2;
    fontRow = rowOff[3:1];
    shifted = font << (6'(fontRow) * 6'd5);
    bits_o  = 8'h00;
    if (row_i >= 4'd2) begin
      bits_o = {1'b0, shifted[34:30], 2'b00};
    end
  end

endmodule

// File: rtl/vga_tile_render.sv
// Text-mode pixel source for vga_ctrl.
// Ports:
//   clk, rst              pixel clock, synchronous active-high reset
//   pix_x, pix_y          current pixel from vga_ctrl
//   vsync                 frame sync; rising edge advances the blink counter
//   wr_en/wr_addr/wr_data host write port into the 80x30 tile map
//   cursor_en/col/row     blinking inverse-video cursor cell
//   busy                  high while the tile map is being cleared
//   pix_data              RGB444 pixel, two clocks after pix_x/pix_y
module vga_tile_render
  import vga_tile_render_pkg::*;
#(
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        vsync,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic        busy,
  output logic [11:0] pix_data
);

  state_e      state_q, state_d;
  logic [11:0] clearAddr_q, clearAddr_d;
  logic        ramWe;
  logic [11:0] ramWaddr;
  logic [7:0]  ramWdata;
  logic [7:0]  tileMem [TILE_CELLS];

  logic [4:0]  cellRow;
  logic [6:0]  cellCol;
  logic [11:0] cellAddr;
  logic [11:0] rdAddr;
  logic        inRange;
  logic        cursorHit;

  logic [7:0]  tile_q;
  logic [3:0]  ySub_q;
  logic [2:0]  xSub_q;
  logic        inRange_q;
  logic        cursorHit_q;
  logic [11:0] pixData_q, pixData_d;

  logic        vsync_q;
  logic [7:0]  blinkCnt_q;
  logic        blinkPhase_q;

  logic [7:0]  glyphRow;
  logic        pixOn;

  // Clear FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clearAddr_q <= '0;
    end else begin
      state_q     <= state_d;
      clearAddr_q <= clearAddr_d;
    end
  end

  // The single RAM write port belongs to the clear sweep in CLEAR and to
  // the host in RUN; host writes outside the map are dropped.
  always_comb begin
    state_d     = state_q;
    clearAddr_d = clearAddr_q;
    ramWe       = 1'b0;
    ramWaddr    = wr_addr;
    ramWdata    = wr_data;
    case (state_q)
      ST_CLEAR: begin
        ramWe    = 1'b1;
        ramWaddr = clearAddr_q;
        ramWdata = 8'h00;
        if (clearAddr_q == 12'(TILE_CELLS - 1)) begin
          state_d     = ST_RUN;
          clearAddr_d = '0;
        end else begin
          clearAddr_d = clearAddr_q + 12'd1;
        end
      end
      default: begin
        ramWe = wr_en && (wr_addr < 12'(TILE_CELLS));
      end
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  // row*80 + col as shifts; out-of-range pixels read cell 0 to keep the
  // RAM index inside the array, their colour is masked later anyway.
  always_comb begin
    cellRow   = pix_y[8:4];
    cellCol   = pix_x[9:3];
    cellAddr  = ({7'd0, cellRow} << 6) + ({7'd0, cellRow} << 4) + {5'd0, cellCol};
    inRange   = (pix_x < 10'd640) && (pix_y < 10'd480);
    rdAddr    = inRange ? cellAddr : 12'd0;
    cursorHit = cursor_en && inRange && (cellCol == cursor_col) && (cellRow == cursor_row);
  end

  // Tile map RAM: the read sees the old contents when the same cell is
  // written in the same cycle.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      tileMem[ramWaddr] <= ramWdata;
    end
    tile_q <= tileMem[rdAddr];
  end

  // First pipeline stage: pixel position info travelling with the RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      ySub_q      <= '0;
      xSub_q      <= '0;
      inRange_q   <= 1'b0;
      cursorHit_q <= 1'b0;
    end else begin
      ySub_q      <= pix_y[3:0];
      xSub_q      <= pix_x[2:0];
      inRange_q   <= inRange;
      cursorHit_q <= cursorHit;
    end
  end

  vga_glyph_rom u_glyphRom (
    .glyph_i (tile_q[3:0]),
    .row_i   (ySub_q),
    .bits_o  (glyphRow)
  );

  // Second stage: pick the lit bit, apply cursor inversion, choose colour
  always_comb begin
    pixOn     = glyphRow[3'd7 - xSub_q] ^ (cursorHit_q && blinkPhase_q);
    pixData_d = pixOn ? paletteLookup(tile_q[7:4]) : BG_COLOR;
    if (!inRange_q || busy) begin
      pixData_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixData_q <= BG_COLOR;
    end else begin
      pixData_q <= pixData_d;
    end
  end

  assign pix_data = pixData_q;

  // Cursor blink: count vsync rising edges, toggle phase every BLINK_FRAMES
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q) begin
        if (blinkCnt_q == 8'(BLINK_FRAMES - 1)) begin
          blinkCnt_q   <= '0;
          blinkPhase_q <= ~blinkPhase_q;
        end else begin
          blinkCnt_q <= blinkCnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_tile_render.sv
// Directed testbench for vga_tile_render with a 2-frame blink period.
module tb_vga_tile_render;

  localparam logic [11:0] BG   = 12'h000;
  localparam logic [11:0] PAL0 = 12'h444;
  localparam logic [11:0] PAL3 = 12'h0FF;
  localparam logic [11:0] PALF = 12'hCCC;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        vsync;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;
  logic [11:0] pix_data;

  int nAsserts = 0;
  int nFails   = 0;
  int cycles;

  // Rows of the hex '1' glyph: 5x7 font doubled vertically from row 2
  logic [7:0] oneRows [16] = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h30, 8'h30, 8'h10, 8'h10,
                               8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h38, 8'h38};

  vga_tile_render #(
    .BG_COLOR     (BG),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .vsync      (vsync),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .pix_data   (pix_data)
  );

  always #5 clk = ~clk;

  // Drive a pixel position and wait out the two-clock pipeline
  task automatic applyStimulus(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] expected);
    nAsserts++;
    assert (pix_data === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: pix_data observed %h expected %h", tag, pix_data, expected);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic hostWrite(input logic [11:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Probe pixel (x_sub 3, y_sub 2) is lit for glyphs 0, 1 and F
  task automatic checkCell(input string tag, input int addr, input logic [11:0] expected);
    applyStimulus((addr % 80) * 8 + 3, (addr / 80) * 16 + 2);
    checkOutput(tag, expected);
  endtask

  task automatic pulseVsync();
    vsync = 1'b1;
    @(posedge clk);
    #1;
    vsync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic waitClear(input string tag);
    cycles = 0;
    while (busy && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkValue(tag, cycles, 2400);
  endtask

  initial begin
    rst        = 1'b1;
    pix_x      = 10'd275;
    pix_y      = 10'd242;
    vsync      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    cursor_en  = 1'b0;
    cursor_col = '0;
    cursor_row = '0;

    @(posedge clk);
    #1;
    checkValue("reset_busy", int'(busy), 1);
    checkOutput("reset_pix", BG);
    rst = 1'b0;

    // Clear sweep: background output throughout, a write to cell 1234
    // after the sweep passed it must be dropped
    cycles = 0;
    while (busy && cycles < 3000) begin
      wr_en   = (cycles == 2000);
      wr_addr = 12'd1234;
      wr_data = 8'hFF;
      @(posedge clk);
      #1;
      cycles++;
      checkOutput("clear_bg", BG);
    end
    wr_en = 1'b0;
    checkValue("clear_cycles", cycles, 2400);
    checkCell("cell1234_cleared", 1234, PAL0);

    // Glyph '1' in palette 3 at cell 0
    hostWrite(12'd0, 8'h31);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 8; x++) begin
        applyStimulus(x, y);
        checkOutput($sformatf("glyph1_x%0d_y%0d", x, y),
                    oneRows[y][7 - x] ? PAL3 : BG);
      end
    end

    // Writes beyond the map are dropped
    hostWrite(12'h960, 8'hFF);
    hostWrite(12'hFFF, 8'hFF);
    checkCell("oob_cell0", 0, PAL3);
    checkCell("oob_cell352", 352, PAL0);
    checkCell("oob_cell1695", 1695, PAL0);
    checkCell("oob_cell2047", 2047, PAL0);
    checkCell("oob_cell2399", 2399, PAL0);

    // Host write accepted in RUN is visible
    hostWrite(12'd2399, 8'hFF);
    checkCell("write_cell2399", 2399, PALF);

    // Edge pixels with nonzero content stay background
    hostWrite(12'd80, 8'hFF);
    applyStimulus(640, 2);
    checkOutput("edge_x640", BG);
    applyStimulus(3, 480);
    checkOutput("edge_y480", BG);

    // Cursor at (col 5, row 2) = cell 165 holding '1' in palette 3
    hostWrite(12'd165, 8'h31);
    cursor_en  = 1'b1;
    cursor_col = 7'd5;
    cursor_row = 5'd2;
    applyStimulus(43, 34);
    checkOutput("cur_ph0_lit", PAL3);
    applyStimulus(40, 34);
    checkOutput("cur_ph0_unlit", BG);
    pulseVsync();
    applyStimulus(43, 34);
    checkOutput("cur_one_pulse", PAL3);
    pulseVsync();
    applyStimulus(43, 34);
    checkOutput("cur_ph1_lit", BG);
    applyStimulus(40, 34);
    checkOutput("cur_ph1_unlit", PAL3);
    applyStimulus(3, 2);
    checkOutput("cur_other_cell", PAL3);
    pulseVsync();
    pulseVsync();
    applyStimulus(43, 34);
    checkOutput("cur_ph0_again", PAL3);
    cursor_en = 1'b0;
    pulseVsync();
    pulseVsync();
    applyStimulus(43, 34);
    checkOutput("cur_disabled_lit", PAL3);
    applyStimulus(40, 34);
    checkOutput("cur_disabled_unlit", BG);

    // Phase is now 1: inversion active, but never outside the screen
    cursor_en  = 1'b1;
    cursor_col = 7'd0;
    cursor_row = 5'd0;
    applyStimulus(0, 2);
    checkOutput("cur_cell0_inv", PAL3);
    cursor_col = 7'd80;
    applyStimulus(640, 2);
    checkOutput("cur_edge_x640", BG);
    cursor_col = 7'd0;
    cursor_row = 5'd30;
    applyStimulus(3, 480);
    checkOutput("cur_edge_y480", BG);
    cursor_en = 1'b0;

    // Reset in the middle of a clear restarts it from cell 0
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    checkValue("midclear_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkValue("restart_busy", int'(busy), 1);
    waitClear("restart_cycles");
    checkCell("restart_cell0", 0, PAL0);
    checkCell("restart_cell2399", 2399, PAL0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
